// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: streams W-bit unsigned operands into a registered 3:2
// carry-save accumulator. On the last operand of a frame it resolves S+C
// with a single carry-propagate add and holds the result on a valid/ready
// output port.
// Optional build macro: CSA_ACC_SAT_EN makes out_sum saturate to all-ones
// for frames that overflowed. Without it the result is always the modular sum.
module csa_accum_ctrl #(
  parameter int unsigned W       = 4,
  parameter int unsigned MAX_OPS = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [W-1:0]                        in_data,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [W+$clog2(MAX_OPS)-1:0]        out_sum,
  output logic [$clog2(MAX_OPS):0]            out_count,
  output logic                                out_ovf,
  output logic                                busy
);

  localparam int unsigned ACC_W = W + $clog2(MAX_OPS);
  localparam int unsigned CNT_W = $clog2(MAX_OPS) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   s_q, s_d;
  logic [ACC_W-1:0]   c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic [ACC_W-1:0]   d_ext;
  logic [ACC_W-1:0]   maj;
  logic [CNT_W-1:0]   cnt_inc;

  // Next-state, carry-save datapath and output register inputs.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    accept  = in_valid & in_ready_q;
    d_ext   = ACC_W'(in_data);
    maj     = (s_q & c_q) | (s_q & d_ext) | (c_q & d_ext);
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          s_d     = d_ext;
          c_d     = '0;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? RESOLVE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          s_d   = s_q ^ c_q ^ d_ext;
          c_d   = {maj[ACC_W-2:0], 1'b0};
          cnt_d = cnt_inc;
          if (cnt_q == CNT_W'(MAX_OPS)) ovf_d = 1'b1;
          if (in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
`ifdef CSA_ACC_SAT_EN
        out_sum_d = ovf_q ? {ACC_W{1'b1}} : s_q + c_q;
`else
        out_sum_d = s_q + c_q;
`endif
        out_count_d = cnt_q;
        out_ovf_d   = ovf_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake/status flags are registered, so decode them from the next state.
    in_ready_d = (state_d == IDLE) || (state_d == ACC);
    busy_d     = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl with hand-computed expectations.
module tb_csa_accum_ctrl;

  localparam int unsigned W     = 4;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;

  csa_accum_ctrl #(.W(4), .MAX_OPS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [W-1:0] d, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    if (!done) check("beat_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for a result (bounded), check it, then complete the handshake.
  task automatic take_result(input string tag, input int exp_sum, input int exp_cnt, input int exp_ovf);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum),   32'(exp_sum));
    check({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
    check({tag, "_ovf"},   32'(out_ovf),   32'(exp_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: 3,5,7,9 back-to-back; result registered one edge after RESOLVE.
    send_beat(4'd3, 1'b0);
    check("t1_busy_acc", 32'(busy), 32'd1);
    send_beat(4'd5, 1'b0);
    send_beat(4'd7, 1'b0);
    send_beat(4'd9, 1'b1);
    check("t1_resolve_valid", 32'(out_valid), 32'd0);
    check("t1_resolve_ready", 32'(in_ready),  32'd0);
    tick();
    check("t1_hold_valid", 32'(out_valid), 32'd1);
    take_result("t1", 24, 4, 0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // 2: single-beat frame; in_ready low through RESOLVE and HOLD.
    send_beat(4'd15, 1'b1);
    check("t2_resolve_ready", 32'(in_ready), 32'd0);
    tick();
    check("t2_hold_ready", 32'(in_ready), 32'd0);
    take_result("t2", 15, 1, 0);
    check("t2_sum_kept", 32'(out_sum), 32'd15);

    // 3: 18 operands of 15 overflow the 16-operand guarantee.
    for (int i = 0; i < 18; i++) send_beat(4'd15, (i == 17));
`ifdef CSA_ACC_SAT_EN
    take_result("t3", 255, 18, 1);
`else
    take_result("t3", 14, 18, 1);
`endif

    // 4: bubbles between operands leave the accumulation untouched.
    send_beat(4'd1, 1'b0);
    tick(); tick();
    check("t4_gap_busy",  32'(busy),     32'd1);
    check("t4_gap_ready", 32'(in_ready), 32'd1);
    send_beat(4'd2, 1'b0);
    tick(); tick(); tick();
    send_beat(4'd3, 1'b1);
    take_result("t4", 6, 3, 0);

    // 5: back-pressure in HOLD with in_valid high; nothing accepted.
    send_beat(4'd2, 1'b1);
    tick();
    in_valid = 1'b1;
    in_data  = 4'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_sum",   32'(out_sum),   32'd2);
      check("t5_hold_ready", 32'(in_ready),  32'd0);
      tick();
    end
    check("t5_hold_count", 32'(out_count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_idle_ready", 32'(in_ready),  32'd1);
    check("t5_idle_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t5_next_accepted", 32'(in_ready), 32'd0);
    check("t5_next_busy",     32'(busy),     32'd1);
    take_result("t5", 7, 1, 0);

    // 6: asynchronous reset mid-frame, then a fresh frame.
    send_beat(4'd4, 1'b0);
    send_beat(4'd5, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_busy",      32'(busy),      32'd0);
    check("t6_rst_out_sum",   32'(out_sum),   32'd0);
    check("t6_rst_out_count", 32'(out_count), 32'd0);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_out_ovf",   32'(out_ovf),   32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("t6_rel_ready", 32'(in_ready), 32'd1);
    send_beat(4'd4, 1'b0);
    send_beat(4'd4, 1'b1);
    take_result("t6", 8, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
